// File: rtl/alu_chain_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_chain_sequencer_if
// Description : Command, operand, result, status and ALU-side signals of the
//               multi-word ALU chain sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_chain_sequencer_if #(
    parameter int WC_WIDTH = 3
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [WC_WIDTH-1:0] cmd_words;
    logic                cmd_carry_in;

    logic                opd_valid;
    logic                opd_ready;
    logic [15:0]         opd_a;
    logic [15:0]         opd_b;

    logic                res_valid;
    logic                res_ready;
    logic [15:0]         res_data;
    logic                res_last;

    logic                done;
    logic                flag_carry;
    logic                flag_overflow;
    logic                flag_zero;
    logic                flag_negative;

    logic [15:0]         alu_a;
    logic [15:0]         alu_b;
    logic [4:0]          alu_code;
    logic                alu_carry_in;
    logic [15:0]         alu_result;
    logic                alu_carry_out;

    modport slave (
        input  cmd_valid, cmd_op, cmd_words, cmd_carry_in,
        input  opd_valid, opd_a, opd_b,
        input  res_ready,
        input  alu_result, alu_carry_out,
        output cmd_ready, opd_ready,
        output res_valid, res_data, res_last,
        output done, flag_carry, flag_overflow, flag_zero, flag_negative,
        output alu_a, alu_b, alu_code, alu_carry_in
    );

    modport master (
        output cmd_valid, cmd_op, cmd_words, cmd_carry_in,
        output opd_valid, opd_a, opd_b,
        output res_ready,
        output alu_result, alu_carry_out,
        input  cmd_ready, opd_ready,
        input  res_valid, res_data, res_last,
        input  done, flag_carry, flag_overflow, flag_zero, flag_negative,
        input  alu_a, alu_b, alu_code, alu_carry_in
    );
endinterface
`default_nettype wire

// File: rtl/alu_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_chain_sequencer
// Description : Drives an external 16-bit ALU through 16xN-bit add/subtract,
//               chaining carry word to word and streaming registered results.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_chain_sequencer #(
    parameter int MAX_WORDS = 4,
    parameter int WC_WIDTH  = 3
) (
    input wire                   clock,
    input wire                   reset_n,
    alu_chain_sequencer_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [4:0] c_CODE_ADD  = 5'h0A;
    localparam logic [4:0] c_CODE_SUB  = 5'h0C;
    localparam logic [4:0] c_CODE_NONE = 5'h00;

    localparam logic [WC_WIDTH-1:0] c_WC_ONE = WC_WIDTH'(1);
    localparam logic [WC_WIDTH-1:0] c_WC_MAX = WC_WIDTH'(MAX_WORDS);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [1:0]          r_op;
    logic [WC_WIDTH-1:0] r_words;
    logic [WC_WIDTH-1:0] r_idx;
    logic                r_carry;
    logic                r_zero_acc;
    logic [15:0]         r_res_data;
    logic                r_res_valid;
    logic                r_res_last;
    logic                r_flag_carry;
    logic                r_flag_overflow;
    logic                r_flag_zero;
    logic                r_flag_negative;

    logic                w_cmd_acc;
    logic                w_opd_ready;
    logic                w_opd_acc;
    logic                w_res_drain;
    logic                w_last_word;
    logic                w_overflow;
    logic                w_result_zero;
    logic [WC_WIDTH-1:0] w_words_clamped;

    assign w_cmd_acc     = bus.cmd_valid & (r_state == c_ST_IDLE);
    assign w_opd_ready   = (r_state == c_ST_RUN) & (~r_res_valid | bus.res_ready);
    assign w_opd_acc     = w_opd_ready & bus.opd_valid;
    assign w_res_drain   = r_res_valid & bus.res_ready;
    assign w_last_word   = (r_idx == (r_words - c_WC_ONE));
    assign w_result_zero = (bus.alu_result == 16'h0000);

    always_comb begin
        w_words_clamped = bus.cmd_words;
        if (bus.cmd_words == '0) begin
            w_words_clamped = c_WC_ONE;
        end else if (bus.cmd_words > c_WC_MAX) begin
            w_words_clamped = c_WC_MAX;
        end
    end

    // Subtraction is B - A, so B's sign is the reference for signed overflow.
    always_comb begin
        w_overflow = 1'b0;
        case (r_op)
            2'b00:   w_overflow = bus.alu_carry_out;
            2'b01:   w_overflow = ~(bus.opd_a[15] ^ bus.opd_b[15]) &
                                   (bus.opd_b[15] ^ bus.alu_result[15]);
            2'b10:   w_overflow = ~bus.alu_carry_out;
            default: w_overflow =  (bus.opd_a[15] ^ bus.opd_b[15]) &
                                   (bus.opd_b[15] ^ bus.alu_result[15]);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_cmd_acc) w_next_state = c_ST_RUN;
            c_ST_RUN:   if (w_opd_acc && w_last_word) w_next_state = c_ST_DRAIN;
            c_ST_DRAIN: if (w_res_drain) w_next_state = c_ST_DONE;
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // Only the final word uses the signed codes, so intermediate words never
    // raise signed status inside the ALU.
    always_comb begin
        bus.cmd_ready    = 1'b0;
        bus.opd_ready    = 1'b0;
        bus.done         = 1'b0;
        bus.alu_code     = c_CODE_NONE;
        bus.alu_carry_in = 1'b0;
        case (r_state)
            c_ST_IDLE: bus.cmd_ready = 1'b1;
            c_ST_RUN: begin
                bus.opd_ready    = w_opd_ready;
                bus.alu_carry_in = r_carry;
                if (w_last_word) begin
                    bus.alu_code = c_CODE_ADD + {3'b000, r_op};
                end else begin
                    bus.alu_code = r_op[1] ? c_CODE_SUB : c_CODE_ADD;
                end
            end
            c_ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op            <= 2'b00;
            r_words         <= '0;
            r_idx           <= '0;
            r_carry         <= 1'b0;
            r_zero_acc      <= 1'b0;
            r_res_data      <= 16'h0000;
            r_res_valid     <= 1'b0;
            r_res_last      <= 1'b0;
            r_flag_carry    <= 1'b0;
            r_flag_overflow <= 1'b0;
            r_flag_zero     <= 1'b0;
            r_flag_negative <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_op            <= bus.cmd_op;
                r_words         <= w_words_clamped;
                r_idx           <= '0;
                r_carry         <= bus.cmd_op[1] ? 1'b1 : bus.cmd_carry_in;
                r_zero_acc      <= 1'b1;
                r_flag_carry    <= 1'b0;
                r_flag_overflow <= 1'b0;
                r_flag_zero     <= 1'b0;
                r_flag_negative <= 1'b0;
            end
            if (w_opd_acc) begin
                r_res_data  <= bus.alu_result;
                r_res_valid <= 1'b1;
                r_res_last  <= w_last_word;
                r_carry     <= bus.alu_carry_out;
                r_zero_acc  <= r_zero_acc & w_result_zero;
                r_idx       <= r_idx + c_WC_ONE;
                if (w_last_word) begin
                    r_flag_carry    <= bus.alu_carry_out;
                    r_flag_overflow <= w_overflow;
                    r_flag_zero     <= r_zero_acc & w_result_zero;
                    r_flag_negative <= bus.alu_result[15];
                end
            end else if (w_res_drain) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_a         = bus.opd_a;
    assign bus.alu_b         = bus.opd_b;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_data      = r_res_data;
    assign bus.res_last      = r_res_last;
    assign bus.flag_carry    = r_flag_carry;
    assign bus.flag_overflow = r_flag_overflow;
    assign bus.flag_zero     = r_flag_zero;
    assign bus.flag_negative = r_flag_negative;

endmodule
`default_nettype wire

// File: tb/tb_alu_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_chain_sequencer
// Description : Scoreboard bench for alu_chain_sequencer with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_chain_sequencer;
    logic clock = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   last_acc = 0;

    logic [16:0] q_res[$];
    logic [5:0]  q_alu[$];
    logic [3:0]  exp_flags;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    alu_chain_sequencer_if #(.WC_WIDTH(3)) bus ();

    alu_chain_sequencer #(.MAX_WORDS(4), .WC_WIDTH(3)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural model of the external ALU (sub computes B - A).
    always_comb begin
        logic [16:0] sum;
        sum = 17'h0;
        case (bus.alu_code)
            5'h0A, 5'h0B: sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'h0, bus.alu_carry_in};
            5'h0C, 5'h0D: sum = {1'b0, ~bus.alu_a} + {1'b0, bus.alu_b} + {16'h0, bus.alu_carry_in};
            default:      sum = 17'h0;
        endcase
        bus.alu_result    = sum[15:0];
        bus.alu_carry_out = sum[16];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.opd_valid && bus.opd_ready) begin
                if (q_alu.size() == 0) check("alu_extra", 1, 0);
                else check("alu_drive", {26'h0, bus.alu_code, bus.alu_carry_in}, {26'h0, q_alu.pop_front()});
            end
            if (bus.res_valid && bus.res_ready) begin
                if (q_res.size() == 0) check("res_extra", 1, 0);
                else check("res_word", {15'h0, bus.res_last, bus.res_data}, {15'h0, q_res.pop_front()});
            end
            if (bus.done) begin
                done_count++;
                check("flags", {28'h0, bus.flag_carry, bus.flag_overflow, bus.flag_zero, bus.flag_negative},
                      {28'h0, exp_flags});
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] words, input logic cin,
                           input logic [63:0] a, input logic [63:0] b,
                           input bit stall, input int abort_after);
        int n, t;
        logic [64:0] full, s, lm, m, opa;
        logic c0, carry, r15, a15, b15, ov;
        logic [4:0] code;
        n   = (words == 3'd0) ? 1 : ((words > 3'd4) ? 4 : int'(words));
        m   = (65'd1 << (16 * n)) - 65'd1;
        opa = op[1] ? {1'b0, ~a} : {1'b0, a};
        c0  = op[1] ? 1'b1 : cin;
        full = (opa & m) + ({1'b0, b} & m) + {64'h0, c0};
        for (int i = 0; i < n; i++) begin
            lm   = (65'd1 << (16 * i)) - 65'd1;
            s    = (opa & lm) + ({1'b0, b} & lm) + {64'h0, c0};
            code = (i == n - 1) ? (5'h0A + {3'b000, op}) : (op[1] ? 5'h0C : 5'h0A);
            q_alu.push_back({code, s[16 * i]});
            q_res.push_back({(i == n - 1), full[16 * i +: 16]});
        end
        carry = full[16 * n];
        r15   = full[16 * n - 1];
        a15   = a[16 * n - 1];
        b15   = b[16 * n - 1];
        case (op)
            2'b00:   ov = carry;
            2'b01:   ov = ~(a15 ^ b15) & (b15 ^ r15);
            2'b10:   ov = ~carry;
            default: ov = (a15 ^ b15) & (b15 ^ r15);
        endcase
        exp_flags = {carry, ov, ((full & m) == 65'd0), r15};

        @(posedge clock); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_words = words; bus.cmd_carry_in = cin;
        bus.res_ready = !stall;
        @(negedge clock);
        check("cmd_ready", {31'h0, bus.cmd_ready}, 1);
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clock);
        check("flag_clear", {28'h0, bus.flag_carry, bus.flag_overflow, bus.flag_zero, bus.flag_negative}, 0);
        @(posedge clock); #1;

        fork
            begin : p_drive
                for (int i = 0; i < n && i != abort_after; i++) begin
                    logic acc;
                    int tmo;
                    bus.opd_valid = 1'b1;
                    bus.opd_a = a[16 * i +: 16];
                    bus.opd_b = b[16 * i +: 16];
                    acc = 1'b0;
                    tmo = 0;
                    while (!acc && tmo < 100) begin
                        @(negedge clock);
                        acc = bus.opd_ready;
                        if (acc && i == n - 1) last_acc = cyc;
                        @(posedge clock); #1;
                        tmo++;
                    end
                    if (!acc) check("opd_timeout", 0, 1);
                end
                bus.opd_valid = 1'b0;
            end
            begin : p_stall
                if (stall) begin
                    int ts;
                    ts = 0;
                    @(negedge clock);
                    while (!bus.res_valid && ts < 100) begin
                        @(negedge clock);
                        ts++;
                    end
                    for (int k = 0; k < 3; k++) begin
                        check("stall_data", {16'h0, bus.res_data}, {16'h0, q_res[0][15:0]});
                        check("stall_ordy", {31'h0, bus.opd_ready}, 0);
                        @(posedge clock); #1;
                        if (k < 2) @(negedge clock);
                    end
                    bus.res_ready = 1'b1;
                end
            end
        join

        if (abort_after < 0) begin
            t = 0;
            while (!bus.done && t < 100) begin
                @(negedge clock);
                t++;
            end
            check("done_seen", {31'h0, bus.done}, 1);
            if (!stall) check("done_lat", cyc - last_acc, 2);
            @(negedge clock);
            check("done_pulse", {31'h0, bus.done}, 0);
            check("flag_hold", {28'h0, bus.flag_carry, bus.flag_overflow, bus.flag_zero, bus.flag_negative},
                  {28'h0, exp_flags});
            check("q_empty", q_res.size(), 0);
        end
    endtask

    initial begin
        logic [63:0] ra, rb;
        int base;
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_words = 3'd0; bus.cmd_carry_in = 1'b0;
        bus.opd_valid = 1'b0; bus.opd_a = 16'h0; bus.opd_b = 16'h0; bus.res_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_outs", {22'h0, bus.res_valid, bus.res_last, bus.done, bus.opd_ready, bus.alu_code,
                           bus.alu_carry_in}, 0);
        check("rst_data", {16'h0, bus.res_data}, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 1);

        // Carry chain, borrow chain, signed overflow.
        run_cmd(2'b00, 3'd2, 1'b0, 64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001, 0, -1);
        run_cmd(2'b10, 3'd2, 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0001_0000, 0, -1);
        run_cmd(2'b01, 3'd1, 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_7FFF, 0, -1);
        check("sovf_flags", {28'h0, bus.flag_carry, bus.flag_overflow, bus.flag_zero, bus.flag_negative},
              32'h5);

        // Same N=3 command unstalled and stalled.
        run_cmd(2'b00, 3'd3, 1'b1, 64'h0000_8001_FFFF_FFFE, 64'h0000_7FFF_0000_0003, 0, -1);
        run_cmd(2'b00, 3'd3, 1'b1, 64'h0000_8001_FFFF_FFFE, 64'h0000_7FFF_0000_0003, 1, -1);

        // Word-count clamping and zero flag.
        run_cmd(2'b10, 3'd0, 1'b0, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234, 0, -1);
        check("zero_flags", {28'h0, bus.flag_carry, bus.flag_overflow, bus.flag_zero, bus.flag_negative},
              32'hA);
        run_cmd(2'b11, 3'd7, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h8765_4321_0FED_CBA9, 0, -1);

        for (int r = 0; r < 4; r++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ra, rb, bit'($urandom_range(0, 1)), -1);
        end

        // Reset while a 3-word command is in flight.
        run_cmd(2'b00, 3'd3, 1'b0, 64'h0000_1111_2222_3333, 64'h0000_4444_5555_6666, 0, 1);
        reset_n = 1'b0;
        #1;
        base = done_count;
        check("mid_rst_outs", {22'h0, bus.res_valid, bus.res_last, bus.done, bus.opd_ready, bus.alu_code,
                               bus.alu_carry_in}, 0);
        check("mid_rst_flags", {28'h0, bus.flag_carry, bus.flag_overflow, bus.flag_zero, bus.flag_negative}, 0);
        q_res.delete();
        q_alu.delete();
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("mid_rst_ready", {31'h0, bus.cmd_ready}, 1);
        check("mid_rst_nodone", done_count - base, 0);
        run_cmd(2'b00, 3'd1, 1'b0, 64'h2, 64'h3, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/alu_chain_sequencer.md
Name: alu_chain_sequencer

Overview:
- Sequences the single-cycle combinational 16-bit ALU through multi-word (16×N bit) add/subtract operations.
- Operand word pairs are streamed in low word first. Each pair is issued to the ALU with the carry chained from the previous word. Each result word is registered and streamed out.
- Whole-operation status flags are produced at the end.
- Sits between the instruction/datapath control and an external alu instance; owns alu_code and alu_carry_in for the duration of a command.

Parameters:
- MAX_WORDS, 4, maximum words per command (1..7).
- WC_WIDTH, 3, width of cmd_words.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 add unsigned, 01 add signed, 10 sub unsigned, 11 sub signed (sub = B − A).
- cmd_words  in  WC_WIDTH  word count; 0 → 1; >MAX_WORDS → MAX_WORDS.
- cmd_carry_in  in  1  initial carry for add ops; ignored for sub (initial carry forced 1).
- opd_valid  in  1  operand pair valid.
- opd_ready  out  1  operand pair accepted when opd_valid & opd_ready.
- opd_a  in  16  operand A word.
- opd_b  in  16  operand B word.
- res_valid  out  1  result word valid.
- res_ready  in  1  result consumer ready.
- res_data  out  16  registered result word.
- res_last  out  1  marks final result word.
- done  out  1  one-cycle pulse; flags valid from this cycle until next cmd accept.
- flag_carry  out  1  final ALU carry out.
- flag_overflow  out  1  see Behaviour.
- flag_zero  out  1  all result words zero.
- flag_negative  out  1  bit 15 of final word.
- alu_a  out  16  to ALU a (combinational from opd_a).
- alu_b  out  16  to ALU b (combinational from opd_b).
- alu_code  out  5  to ALU.
- alu_carry_in  out  1  to ALU.
- alu_result  in  16  from ALU.
- alu_carry_out  in  1  from ALU.

Behaviour:
- Reset (async, reset_n low): state IDLE. cmd_ready=1 after release. All other outputs 0, including flags, alu_code=0x00 and alu_carry_in=0. Internal word counter, carry and zero accumulators cleared. Reset mid-command abandons it; no done is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd_valid & cmd_ready: latch op, the clamped word count N, and carry_reg (cmd_carry_in for add, 1 for sub).
  - Set zero_acc=1, word index=0, then go to RUN.
- RUN:
  - opd_ready = ~res_valid | res_ready (a single result register that may drain and refill in the same cycle).
  - ALU drive: alu_a=opd_a, alu_b=opd_b, alu_carry_in=carry_reg.
  - alu_code for non-final words: 0x0A for add, 0x0C for sub.
  - alu_code for the final word follows cmd_op: 0x0A, 0x0B, 0x0C, 0x0D.
  - Outside RUN: alu_code=0x00, alu_carry_in=0.
  - On an operand accept:
    - res_data←alu_result, res_valid←1, res_last←(index==N−1).
    - carry_reg←alu_carry_out.
    - zero_acc←zero_acc & (alu_result==0).
    - index++.
  - Final accept: capture flags, then go to DRAIN.
- Latency: result word appears 1 cycle after operand accept. Peak throughput is 1 word/cycle when res_ready is held high.
- Back-pressure: res_valid & ~res_ready holds res_data/res_last stable and forces opd_ready=0. No operand is consumed, so carry_reg is unchanged.
- DRAIN: opd_ready=0. On res_valid & res_ready go to DONE, with res_valid←0.
- DONE: done=1 for exactly one cycle, then go to IDLE. Flags hold until the next cmd accept, which clears them to 0.
- Flags (computed on the final word, with r = alu_result):
  - flag_carry = alu_carry_out.
  - flag_negative = r[15].
  - flag_zero = zero_acc & (r==0).
  - flag_overflow:
    - add unsigned: = carry.
    - sub unsigned: = ~carry (borrow).
    - add signed: = ~(a15^b15) & (b15^r15).
    - sub signed: = (a15^b15) & (b15^r15).
- cmd_valid outside IDLE is ignored (cmd_ready=0). opd_valid in IDLE/DRAIN/DONE is ignored.

Test Plan:
- Carry chain: add unsigned, N=2, cin=0; pairs (A=FFFF,B=0001), (A=0001,B=0000) -> word 1 driven with alu_carry_in=1; res 0000, 0002 with res_last on second; carry=0, overflow=0, zero=0.
- Borrow chain: sub unsigned, N=2; pairs (A=0001,B=0000), (A=0000,B=0001) -> word 0 driven with alu_code 0C, alu_carry_in=1; res FFFF, 0000; carry=1, overflow=0, negative=0.
- Signed add overflow: add signed, N=1; A=0001, B=7FFF -> alu_code 0B; res 8000; overflow=1, negative=1, done pulse 2 cycles after accept.
- Back-pressure: N=3 with res_ready low 3 cycles after the first result -> res_data stable; opd_ready=0; second pair not consumed; final results and flags identical to the unstalled run.
- Zero and clamp: sub unsigned, cmd_words=0 (treated as 1); A=B=1234 -> res 0000, zero=1, carry=1. Repeat with cmd_words=7 -> exactly 4 words processed.
- Reset mid-operation: reset_n low after the first of 3 words -> all outputs 0, no done; after release cmd_ready=1 and a fresh N=1 add 0002+0003 returns 0005.
